uart_rx_core: RTL



---
 rtl/uart_rx_core_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 62 ++++++
 rtl/uart_rx_core.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive engine: FSM state encoding,
// default oversampling ratio, mid-bit position helper and majority voter.
package uart_rx_core_pkg;

  // Default oversample ticks per bit.
  localparam int unsigned SAMPLING_FACTOR = 16;

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_START      = 3'd1,
    RX_DATA       = 3'd2,
    RX_PARITY     = 3'd3,
    RX_STOP       = 3'd4,
    RX_BREAK_WAIT = 3'd5
  } rx_state_e;

  // Mid-bit sample count M for a given oversampling ratio.
  function automatic int unsigned half_pulse(input int unsigned os);
    return os / 2;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchronizer, per-bit sample counter and 3-sample
// majority voter around mid-bit.
//   clk, rst  : clock, synchronous active-high reset
//   ena       : oversample tick
//   rx_in     : asynchronous serial line
//   run       : counter runs while high; held at 0 on ticks while low
//   line      : synchronized line level
//   bit_val   : voted bit value, valid while bit_done is high
//   bit_done  : tick that takes the last (M+1) sample of a bit
//   bit_end   : tick on which the sample counter wraps
module uart_rx_sampler
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = SAMPLING_FACTOR
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic rx_in,
  input  logic run,
  output logic line,
  output logic bit_val,
  output logic bit_done,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned M     = half_pulse(OVERSAMPLE);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             samp_a_q;
  logic             samp_b_q;

  // Synchronizer runs every clk; counter and sample captures only on ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_in};
      if (ena) begin
        if (!run || (cnt_q == CNT_W'(OVERSAMPLE - 1))) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (run && (cnt_q == CNT_W'(M - 1))) samp_a_q <= sync_q[1];
        if (run && (cnt_q == CNT_W'(M)))     samp_b_q <= sync_q[1];
      end
    end
  end

  // Third vote is the live synchronized line at count M+1.
  assign line     = sync_q[1];
  assign bit_val  = majority3(samp_a_q, samp_b_q, sync_q[1]);
  assign bit_done = ena && run && (cnt_q == CNT_W'(M + 1));
  assign bit_end  = ena && run && (cnt_q == CNT_W'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receive engine. Oversamples rx_in on ena ticks, votes
// each bit at mid-bit and delivers one word per frame with a valid strobe
// plus parity, framing and break status.
//   clk, rst   : clock, synchronous active-high reset
//   ena        : oversample tick (OVERSAMPLE x baud)
//   rx_in      : serial line, idle high
//   data_out   : last received word
//   data_valid : one-clk pulse per completed frame
//   parity_err : parity mismatch on the reported frame
//   frame_err  : a stop bit was sampled low
//   break_det  : data, parity and first stop bit all sampled low
//   busy       : high from start detection until return to idle
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = SAMPLING_FACTOR,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic        ODD   = 1'(PARITY_ODD);

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic [DATA_BITS-1:0] data_out_d;
  logic                 data_valid_d, parity_err_d, frame_err_d, break_det_d, busy_d;
  logic                 zero_now, ferr_now;

  logic run_c, line, bit_val, bit_done, bit_end;

  assign run_c = (state_q != RX_IDLE) && (state_q != RX_BREAK_WAIT);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .rx_in    (rx_in),
    .run      (run_c),
    .line     (line),
    .bit_val  (bit_val),
    .bit_done (bit_done),
    .bit_end  (bit_end)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      parity_err <= parity_err_d;
      frame_err  <= frame_err_d;
      break_det  <= break_det_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    par_d        = par_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    zero_d       = zero_q;
    data_out_d   = data_out;
    data_valid_d = 1'b0;
    parity_err_d = parity_err;
    frame_err_d  = frame_err;
    break_det_d  = break_det;
    zero_now     = zero_q;
    ferr_now     = ferr_q;

    unique case (state_q)
      RX_IDLE: begin
        if (ena && !line) begin
          state_d  = RX_START;
          shift_d  = '0;
          bitcnt_d = '0;
          par_d    = 1'b0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
          zero_d   = 1'b1;
        end
      end

      RX_START: begin
        if (bit_done && bit_val) begin
          state_d = RX_IDLE;
        end else if (bit_end) begin
          state_d = RX_DATA;
        end
      end

      RX_DATA: begin
        // LSB arrives first; after DATA_BITS right shifts it sits in bit 0.
        if (bit_done) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ bit_val;
          zero_d  = zero_q & ~bit_val;
          if (bitcnt_q != BIT_W'(DATA_BITS)) bitcnt_d = bitcnt_q + BIT_W'(1);
        end
        // Uses bitcnt_d so a mid-bit sample on the wrap tick is still counted.
        if (bit_end && (bitcnt_d == BIT_W'(DATA_BITS))) begin
          bitcnt_d = '0;
          state_d  = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
        end
      end

      RX_PARITY: begin
        if (bit_done) begin
          perr_d = bit_val ^ par_q ^ ODD;
          zero_d = zero_q & ~bit_val;
        end
        if (bit_end) begin
          bitcnt_d = '0;
          state_d  = RX_STOP;
        end
      end

      RX_STOP: begin
        if (bit_done) begin
          if (bitcnt_q == '0) zero_now = zero_q & ~bit_val;
          ferr_now = ferr_q | ~bit_val;
          if (bitcnt_q == BIT_W'(STOP_BITS - 1)) begin
            // Complete at mid-point of the last stop bit.
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            parity_err_d = perr_q;
            frame_err_d  = ferr_now;
            break_det_d  = zero_now;
            state_d      = ferr_now ? RX_BREAK_WAIT : RX_IDLE;
          end else begin
            ferr_d   = ferr_now;
            zero_d   = zero_now;
            bitcnt_d = bitcnt_q + BIT_W'(1);
          end
        end
      end

      RX_BREAK_WAIT: begin
        if (ena && line) state_d = RX_IDLE;
      end

      default: state_d = RX_IDLE;
    endcase

    busy_d = (state_d != RX_IDLE);
  end

endmodule
